// File: rtl/audio_clkgen.sv
// audio_clkgen: divides the master clock into BCLK and LRCK/frame sync for
// 2-channel (L/R) or N-channel TDM serial audio framing.
// Starting and stopping happen only at frame boundaries, so no partial frame
// is ever emitted.
// Optional build macro: AUDIO_CLKGEN_I2S_DELAY_EN moves every LRCK edge one
// BCLK period earlier. This gives the I2S MSB delay in L/R mode and DSP mode A
// in TDM mode.
`timescale 1ns/1ps
module audio_clkgen #(
  parameter int MCLK_DIV  = 8,
  parameter int SLOT_BITS = 32,
  parameter int CHANNELS  = 2,
  localparam int SLOT_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BIT_W    = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1
) (
  input  logic              mclk_in,
  input  logic              rst,
  input  logic              en,
  output logic              running,
  output logic              bclk,
  output logic              lrck,
  output logic              bit_strobe,
  output logic              frame_strobe,
  output logic [SLOT_W-1:0] slot_idx,
  output logic [BIT_W-1:0]  bit_idx
);

  localparam int DIV_W = $clog2(MCLK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic              div_last;
  logic              bit_last;
  logic              slot_last;
  logic              frame_last;
  logic              lrck_next;
`ifdef AUDIO_CLKGEN_I2S_DELAY_EN
  logic              first_frame;
`endif

  // Wrap detection for the three cascaded counters
  always_comb begin
    div_last   = (div_cnt == DIV_W'(MCLK_DIV - 1));
    bit_last   = (bit_cnt == BIT_W'(SLOT_BITS - 1));
    slot_last  = (slot_cnt == SLOT_W'(CHANNELS - 1));
    frame_last = div_last && bit_last && slot_last;
  end

  // LRCK level for the bit currently held in the counters
  always_comb begin
    lrck_next = 1'b0;
`ifdef AUDIO_CLKGEN_I2S_DELAY_EN
    if (CHANNELS == 2) begin
      // Last bit of a slot already shows the level of the upcoming slot
      lrck_next = bit_last ? (slot_cnt == SLOT_W'(0)) : (slot_cnt == SLOT_W'(1));
    end else begin
      // Sync one bit ahead of slot 0; the very first frame has no
      // preceding bit, so it gets a truncated sync on bit 0 instead
      lrck_next = (bit_last && slot_last) ||
                  (first_frame && slot_cnt == SLOT_W'(0) && bit_cnt == BIT_W'(0));
    end
`else
    if (CHANNELS == 2) begin
      lrck_next = (slot_cnt == SLOT_W'(1));
    end else begin
      lrck_next = (slot_cnt == SLOT_W'(0)) && (bit_cnt == BIT_W'(0));
    end
`endif
  end

  // State machine, counters and registered outputs. The outputs show the
  // counter values of the previous cycle, so each output is a plain flop.
  always_ff @(posedge mclk_in or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      slot_cnt     <= '0;
      running      <= 1'b0;
      bclk         <= 1'b0;
      lrck         <= 1'b0;
      bit_strobe   <= 1'b0;
      frame_strobe <= 1'b0;
      slot_idx     <= '0;
      bit_idx      <= '0;
`ifdef AUDIO_CLKGEN_I2S_DELAY_EN
      first_frame  <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        running      <= 1'b0;
        bclk         <= 1'b0;
        lrck         <= 1'b0;
        bit_strobe   <= 1'b0;
        frame_strobe <= 1'b0;
        slot_idx     <= '0;
        bit_idx      <= '0;
      end else begin
        running      <= 1'b1;
        bclk         <= (div_cnt >= DIV_W'(MCLK_DIV / 2));
        lrck         <= lrck_next;
        bit_strobe   <= (div_cnt == DIV_W'(0));
        frame_strobe <= (div_cnt == DIV_W'(0)) && (bit_cnt == BIT_W'(0)) &&
                        (slot_cnt == SLOT_W'(0));
        slot_idx     <= slot_cnt;
        bit_idx      <= bit_cnt;
      end

      case (state)
        IDLE: begin
          div_cnt  <= '0;
          bit_cnt  <= '0;
          slot_cnt <= '0;
          if (en) begin
            state <= RUN;
`ifdef AUDIO_CLKGEN_I2S_DELAY_EN
            first_frame <= 1'b1;
`endif
          end
        end
        default: begin
          div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
          if (div_last) begin
            bit_cnt <= bit_last ? '0 : bit_cnt + BIT_W'(1);
            if (bit_last) begin
              slot_cnt <= slot_last ? '0 : slot_cnt + SLOT_W'(1);
            end
          end
`ifdef AUDIO_CLKGEN_I2S_DELAY_EN
          if (frame_last) begin
            first_frame <= 1'b0;
          end
`endif
          // A low request only takes effect when the frame completes
          if (frame_last && !en) begin
            state <= IDLE;
          end else begin
            state <= en ? RUN : STOPPING;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_clkgen.sv
// Scoreboard bench for audio_clkgen. The default instance is checked per bit
// against a queue of expected (slot, bit, lrck, frame_strobe) tuples. A second
// instance in TDM mode is checked for sync width and frame period.
`timescale 1ns/1ps
module tb_audio_clkgen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       en2 = 1'b0;
  logic       running, bclk, lrck, bit_strobe, frame_strobe;
  logic [0:0] slot_idx;
  logic [4:0] bit_idx;
  logic       running2, bclk2, lrck2, bs2, fs2;
  logic [2:0] slot_idx2;
  logic [4:0] bit_idx2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int   slot;
    int   bit_i;
    logic lr;
    logic fs;
  } exp_t;

  exp_t sb_q[$];
  bit   mon_on = 1'b0;
  bit   tdm_done = 1'b0;
  int   since_bs = 0;
  int   since_fs = 0;
  bit   seen_bs = 1'b0;
  bit   seen_fs = 1'b0;

  always #5 clk = ~clk;

  audio_clkgen dut (
    .mclk_in(clk), .rst(rst), .en(en), .running(running), .bclk(bclk),
    .lrck(lrck), .bit_strobe(bit_strobe), .frame_strobe(frame_strobe),
    .slot_idx(slot_idx), .bit_idx(bit_idx)
  );

  audio_clkgen #(.MCLK_DIV(2), .SLOT_BITS(32), .CHANNELS(8)) dut_tdm (
    .mclk_in(clk), .rst(rst), .en(en2), .running(running2), .bclk(bclk2),
    .lrck(lrck2), .bit_strobe(bs2), .frame_strobe(fs2),
    .slot_idx(slot_idx2), .bit_idx(bit_idx2)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Expected LRCK level for a given bit of the default L/R frame
  function automatic logic exp_lr(input int s, input int b);
`ifdef AUDIO_CLKGEN_I2S_DELAY_EN
    if (b == 31) return (s == 0);
`endif
    return (s == 1);
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 32; b++) begin
        e.slot  = s;
        e.bit_i = b;
        e.lr    = exp_lr(s, b);
        e.fs    = (s == 0 && b == 0);
        sb_q.push_back(e);
      end
    end
  endtask

  // Monitor: pops one expectation for every bit_strobe and checks spacing
  always @(negedge clk) begin
    exp_t e;
    if (!mon_on) begin
      seen_bs  = 1'b0;
      seen_fs  = 1'b0;
      since_bs = 0;
      since_fs = 0;
    end else begin
      since_bs++;
      since_fs++;
      if (seen_bs && since_bs == 3) check("bclk_low_phase", bclk, 0);
      if (seen_bs && since_bs == 4) check("bclk_rise", bclk, 1);
      if (bit_strobe) begin
        if (seen_bs) check("bclk_period", since_bs, 8);
        check("bclk_low_at_strobe", bclk, 0);
        seen_bs  = 1'b1;
        since_bs = 0;
        if (frame_strobe) begin
          if (seen_fs) check("frame_period", since_fs, 512);
          seen_fs  = 1'b1;
          since_fs = 0;
        end
        check("strobe_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          $display("strobe slot=%0d bit=%0d lrck=%0d fs=%0d (exp %0d/%0d/%0d/%0d)",
                   slot_idx, bit_idx, lrck, frame_strobe, e.slot, e.bit_i, e.lr, e.fs);
          check("slot_idx", slot_idx, e.slot);
          check("bit_idx", bit_idx, e.bit_i);
          check("lrck", lrck, e.lr);
          check("frame_strobe", frame_strobe, e.fs);
        end
      end else begin
        check("fs_without_bs", frame_strobe, 0);
      end
    end
  end

  // TDM instance: sync width, frame period and slot range over one full frame
  initial begin
    int n;
    int hi;
    int maxslot;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!fs2 && n < 3000);
      check("tdm_fs_seen", int'(fs2), 1);
    end
    n = 0;
    hi = 0;
    maxslot = 0;
    do begin
      if (lrck2) hi++;
      if (int'(slot_idx2) > maxslot) maxslot = int'(slot_idx2);
      @(negedge clk);
      n++;
    end while (!fs2 && n < 3000);
    $display("tdm frame cycles=%0d sync_cycles=%0d max_slot=%0d", n, hi, maxslot);
    check("tdm_period", n, 512);
    check("tdm_sync_width", hi, 2);
    check("tdm_max_slot", maxslot, 7);
    tdm_done = 1'b1;
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_running", running, 0);
    check("rst_bclk", bclk, 0);
    check("rst_lrck", lrck, 0);
    check("rst_bit_strobe", bit_strobe, 0);
    check("rst_frame_strobe", frame_strobe, 0);
    check("rst_slot_idx", slot_idx, 0);
    check("rst_bit_idx", bit_idx, 0);

    // Start: three frames expected, one-cycle en glitch in the first
    push_frame();
    push_frame();
    push_frame();
    rst    = 1'b0;
    en     = 1'b1;
    en2    = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #1;
    check("start_fs_early", frame_strobe, 0);
    @(posedge clk); #1;
    check("start_fs", frame_strobe, 1);
    check("start_bclk", bclk, 0);
    repeat (300) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;

    // Drop en during bit 5 of slot 1 of the third frame
    n = 0;
    while (sb_q.size() > 26 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("reach_slot1_bit5", sb_q.size(), 26);
    @(negedge clk);
    en = 1'b0;

    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk); #2;
      n++;
    end
    check("last_bit_seen", sb_q.size(), 0);
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (running && n < 20);
    check("stop_delay", n, 8);
    repeat (20) @(negedge clk);
    check("idle_running", running, 0);
    check("idle_bclk", bclk, 0);
    check("idle_lrck", lrck, 0);

    n = 0;
    while (!tdm_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tdm_done", int'(tdm_done), 1);

    // Restart, then asynchronous reset in the middle of a slot
    mon_on = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (100) @(negedge clk);
    check("pre_reset_running", running, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_running", running, 0);
    check("arst_bclk", bclk | lrck | bit_strobe | frame_strobe, 0);
    check("arst_idx", int'(slot_idx) + int'(bit_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("restart_fs_early", frame_strobe, 0);
    @(posedge clk); #1;
    check("restart_fs", frame_strobe, 1);
    check("restart_bs", bit_strobe, 1);
    check("restart_slot", slot_idx, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
